// File: rtl/train_pkg.sv
// Shared types for the training sample sequencer.
// Holds the FSM encoding and the sample memory word layout.
package train_pkg;

  localparam int VEC_W   = 25;
  localparam int LBL_W   = 10;
  localparam int WORD_W  = 35;
  localparam int VEC_LSB = 10;
  localparam int LBL_LSB = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_FETCH,
    S_WAIT_DATA,
    S_PRESENT,
    S_WAIT_DONE,
    S_NEXT,
    S_DONE
  } state_t;

  // Field order matches the memory word: vector on top, label below.
  typedef struct packed {
    logic [VEC_W-1:0] vec;
    logic [LBL_W-1:0] lbl;
  } sample_t;

endpackage

// File: rtl/delay_counter.sv
// Cycle counter that flags the last of P_LEN enabled cycles.
// Held at zero while i_load is high.
module delay_counter #(
  parameter int P_LEN = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire
);

  localparam int CW = (P_LEN > 1) ? $clog2(P_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(P_LEN - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (i_load) begin
      cnt <= '0;
    end else if (i_en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign o_expire = i_en && (cnt == LAST);

endmodule

// File: rtl/train_sequencer.sv
// Steps samples from memory into the network, epoch by epoch,
// with an idle gap before each sample and a completion timeout.
module train_sequencer
  import train_pkg::*;
#(
  parameter int P_SAMPLES = 10,
  parameter int P_GAP     = 200,
  parameter int P_TIMEOUT = 400,
  parameter int P_EPOCHS  = 400,
  localparam int AW = (P_SAMPLES > 1) ? $clog2(P_SAMPLES) : 1,
  localparam int EW = $clog2(P_EPOCHS) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_net_ready,
  input  logic              i_net_done,
  output logic              o_rd_en,
  output logic [AW-1:0]     o_rd_addr,
  input  logic [WORD_W-1:0] i_rd_data,
  output logic [VEC_W-1:0]  o_test_vector,
  output logic [LBL_W-1:0]  o_label,
  output logic              o_valid,
  output logic [EW-1:0]     o_epoch,
  output logic [7:0]        o_timeouts,
  output logic              o_busy,
  output logic              o_end_of_epochs
);

  state_t        state;
  state_t        nxt;
  logic [AW-1:0] addr;
  logic [EW-1:0] epoch;
  logic [7:0]    timeouts;
  sample_t       smp;
  logic          gap_exp;
  logic          to_exp;
  logic          last_addr;
  logic          last_epoch;

  assign last_addr  = (addr == AW'(P_SAMPLES - 1));
  assign last_epoch = (epoch == EW'(P_EPOCHS));

  delay_counter #(.P_LEN(P_GAP)) u_gap (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_load   (state != S_GAP),
    .i_en     ((state == S_GAP) && !i_pause),
    .o_expire (gap_exp)
  );

  delay_counter #(.P_LEN(P_TIMEOUT)) u_tmo (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_load   (state != S_WAIT_DONE),
    .i_en     (state == S_WAIT_DONE),
    .o_expire (to_exp)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:      if (i_start) nxt = S_GAP;
      S_GAP:       if (gap_exp) nxt = S_FETCH;
      S_FETCH:     nxt = S_WAIT_DATA;
      S_WAIT_DATA: nxt = S_PRESENT;
      S_PRESENT:   if (i_net_ready) nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (i_net_done || to_exp) nxt = S_NEXT;
      S_NEXT:      nxt = (last_addr && last_epoch) ? S_DONE : S_GAP;
      S_DONE:      if (i_start) nxt = S_GAP;
      default:     nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      addr     <= '0;
      epoch    <= '0;
      timeouts <= '0;
      smp      <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            addr     <= '0;
            epoch    <= EW'(1);
            timeouts <= '0;
          end
        end
        S_WAIT_DATA: smp <= sample_t'(i_rd_data);
        S_WAIT_DONE: begin
          // A late done still wins over a coincident expiry.
          if (to_exp && !i_net_done && timeouts != 8'hFF)
            timeouts <= timeouts + 8'd1;
        end
        S_NEXT: begin
          unique case (1'b1)
            !last_addr: addr <= addr + 1'b1;
            last_addr && !last_epoch: begin
              addr  <= '0;
              epoch <= epoch + 1'b1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_rd_en         = (state == S_FETCH);
    o_valid         = (state == S_PRESENT) && i_net_ready;
    o_test_vector   = o_valid ? smp.vec : '0;
    o_label         = o_valid ? smp.lbl : '0;
    o_busy          = (state != S_IDLE) && (state != S_DONE);
    o_end_of_epochs = (state == S_DONE);
  end

  assign o_rd_addr  = addr;
  assign o_epoch    = epoch;
  assign o_timeouts = timeouts;

endmodule

// File: tb/tb_train_sequencer.sv
// Bench for train_sequencer: scoreboard of sample order plus
// directed timing, pause, ready, reset and saturation cases.
module tb_train_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, pause, ready, done;
  logic        rd_en;
  logic [1:0]  rd_addr;
  logic [34:0] rd_data;
  logic [24:0] vec;
  logic [9:0]  lbl;
  logic        valid;
  logic [1:0]  epoch;
  logic [7:0]  tmo;
  logic        busy, eoe;

  logic        start2, pause2, ready2, done2;
  logic        rd_en2;
  logic [1:0]  rd_addr2;
  logic [34:0] rd_data2;
  logic [24:0] vec2;
  logic [9:0]  lbl2;
  logic        valid2;
  logic [7:0]  epoch2;
  logic [7:0]  tmo2;
  logic        busy2, eoe2;

  logic [34:0] mem [3];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int nrd      = 0;
  int nval     = 0;
  int nval2    = 0;
  int base_rd  = 0;
  int base_val = 0;
  int rd_cyc  [16];
  int val_cyc [16];
  int done_delay = 5;
  bit done_en    = 1'b1;
  int done_cnt   = 0;

  always #5 clk = ~clk;

  train_sequencer #(
    .P_SAMPLES(3), .P_GAP(4), .P_TIMEOUT(8), .P_EPOCHS(2)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .i_pause(pause), .i_net_ready(ready), .i_net_done(done),
    .o_rd_en(rd_en), .o_rd_addr(rd_addr), .i_rd_data(rd_data),
    .o_test_vector(vec), .o_label(lbl), .o_valid(valid),
    .o_epoch(epoch), .o_timeouts(tmo), .o_busy(busy),
    .o_end_of_epochs(eoe)
  );

  train_sequencer #(
    .P_SAMPLES(3), .P_GAP(1), .P_TIMEOUT(2), .P_EPOCHS(101)
  ) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start2),
    .i_pause(pause2), .i_net_ready(ready2), .i_net_done(done2),
    .o_rd_en(rd_en2), .o_rd_addr(rd_addr2), .i_rd_data(rd_data2),
    .o_test_vector(vec2), .o_label(lbl2), .o_valid(valid2),
    .o_epoch(epoch2), .o_timeouts(tmo2), .o_busy(busy2),
    .o_end_of_epochs(eoe2)
  );

  task automatic check(input string n, input logic [63:0] a,
                       input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en && rd_addr < 2'd3) rd_data <= mem[rd_addr];
    if (rd_en2 && rd_addr2 < 2'd3) rd_data2 <= mem[rd_addr2];
  end

  // Network model: one-cycle done pulse done_delay cycles after valid.
  always @(negedge clk) begin
    if (valid) done_cnt = done_delay + 1;
    else if (done_cnt > 0) done_cnt--;
    done = done_en && (done_cnt == 1);
  end

  // Scoreboard: k-th sample of a run is address k%3 in epoch k/3+1.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_en) begin
        int k;
        k = nrd - base_rd;
        check("rd_addr", 64'(rd_addr), 64'(k % 3));
        if (k < 16) rd_cyc[k] = cyc;
        nrd++;
      end
      if (valid) begin
        int k;
        logic [34:0] w;
        k = nval - base_val;
        w = mem[k % 3];
        check("vector", 64'(vec), 64'(w[34:10]));
        check("label", 64'(lbl), 64'(w[9:0]));
        check("epoch_at_valid", 64'(epoch), 64'(k / 3 + 1));
        if (k < 16) val_cyc[k] = cyc;
        nval++;
      end else begin
        check("idle_zero", 64'({vec, lbl}), 64'd0);
      end
      if (valid2) nval2++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_start(output int c0);
    tick();
    base_rd  = nrd;
    base_val = nval;
    start    = 1'b1;
    c0       = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_eoe(input string n, input int budget);
    int i;
    i = 0;
    while (!eoe && i < budget) begin
      tick();
      i++;
    end
    check(n, 64'(eoe), 64'd1);
  endtask

  initial begin
    int c0;
    int i;
    mem[0] = {25'h1A5A5A5, 10'b0000000001};
    mem[1] = {25'h00F0F0F, 10'b0000100000};
    mem[2] = {25'h1FFFFFF, 10'b1000000000};
    rst_n  = 1'b0;
    start  = 1'b0;
    pause  = 1'b0;
    ready  = 1'b1;
    start2 = 1'b0;
    pause2 = 1'b0;
    ready2 = 1'b1;
    done2  = 1'b0;
    repeat (3) tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_eoe", 64'(eoe), 64'd0);
    check("rst_epoch", 64'(epoch), 64'd0);
    check("rst_tmo", 64'(tmo), 64'd0);
    check("rst_rd", 64'({rd_en, rd_addr, valid}), 64'd0);
    rst_n = 1'b1;
    tick();

    // Nominal run, with a stray start while busy.
    run_start(c0);
    check("busy_run", 64'(busy), 64'd1);
    repeat (18) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_eoe("t1_end", 200);
    check("t1_nvalid", 64'(nval - base_val), 64'd6);
    check("t1_first_rd", 64'(rd_cyc[0] - c0), 64'd5);
    check("t1_first_val", 64'(val_cyc[0] - c0), 64'd7);
    check("t1_rd_span", 64'(rd_cyc[5] - rd_cyc[0]), 64'd65);
    check("t1_tmo", 64'(tmo), 64'd0);
    check("t1_epoch", 64'(epoch), 64'd2);
    check("t1_busy", 64'(busy), 64'd0);

    // Network never finishes: every sample times out.
    done_en = 1'b0;
    run_start(c0);
    wait_eoe("t2_end", 300);
    check("t2_nvalid", 64'(nval - base_val), 64'd6);
    check("t2_period", 64'(rd_cyc[1] - rd_cyc[0]), 64'd16);
    check("t2_tmo", 64'(tmo), 64'd6);

    // Done exactly at expiry counts as done; counter cleared on restart.
    done_en    = 1'b1;
    done_delay = 8;
    run_start(c0);
    check("t3_tmo_clr", 64'(tmo), 64'd0);
    wait_eoe("t3_end", 300);
    check("t3_period", 64'(rd_cyc[1] - rd_cyc[0]), 64'd16);
    check("t3_tmo", 64'(tmo), 64'd0);

    // Pause for 20 cycles in the first gap.
    done_delay = 5;
    run_start(c0);
    pause = 1'b1;
    repeat (20) tick();
    pause = 1'b0;
    wait_eoe("t4_end", 300);
    check("t4_first_rd", 64'(rd_cyc[0] - c0), 64'd25);
    check("t4_nvalid", 64'(nval - base_val), 64'd6);

    // Network not ready for the first 7 cycles of PRESENT.
    ready = 1'b0;
    run_start(c0);
    repeat (13) tick();
    ready = 1'b1;
    wait_eoe("t5_end", 300);
    check("t5_first_rd", 64'(rd_cyc[0] - c0), 64'd5);
    check("t5_first_val", 64'(val_cyc[0] - c0), 64'd14);
    check("t5_nvalid", 64'(nval - base_val), 64'd6);

    // Reset during WAIT_DONE of epoch 2, then restart.
    run_start(c0);
    i = 0;
    while ((nval - base_val) < 4 && i < 200) begin
      tick();
      i++;
    end
    check("t6_reach", 64'(nval - base_val), 64'd4);
    check("t6_epoch2", 64'(epoch), 64'd2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_eoe", 64'(eoe), 64'd0);
    check("t6_epoch", 64'(epoch), 64'd0);
    check("t6_outs", 64'({rd_en, rd_addr, valid, vec, lbl}), 64'd0);
    repeat (6) tick();
    check("t6_idle", 64'({busy, rd_en}), 64'd0);
    run_start(c0);
    check("t6_restart_ep", 64'(epoch), 64'd1);
    wait_eoe("t6_end", 200);
    check("t6_first_rd", 64'(rd_cyc[0] - c0), 64'd5);
    check("t6_nvalid", 64'(nval - base_val), 64'd6);

    // 303 timeouts saturate the counter at 255.
    tick();
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    i = 0;
    while (!eoe2 && i < 5000) begin
      tick();
      i++;
    end
    check("t7_end", 64'(eoe2), 64'd1);
    check("t7_nvalid", 64'(nval2), 64'd303);
    check("t7_epoch", 64'(epoch2), 64'd101);
    check("t7_tmo_sat", 64'(tmo2), 64'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
